// File: rtl/riscv_configs_pkg.sv
// Shared definitions for the data-memory responder: FSM state encodings,
// access-size masks and the size/alignment legality helper.
package riscv_configs;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_e;

  localparam logic [3:0] SIZE_BYTE = 4'b0001;
  localparam logic [3:0] SIZE_HALF = 4'b0011;
  localparam logic [3:0] SIZE_WORD = 4'b1111;

  // True when the size mask is not one of the three legal sizes, or the
  // offset is not naturally aligned for that size.
  function automatic logic size_misaligned(input logic [3:0] sel, input logic [1:0] off);
    case (sel)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return off[0];
      SIZE_WORD: return off != 2'b00;
      default:   return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/riscv_dmem_lane_align.sv
// Byte-lane steering between right-aligned request data and the 32-bit
// memory word: lane mask, store shift, load shift and zero-fill.
module riscv_dmem_lane_align (
  input  logic [3:0]  byte_sel,
  input  logic [1:0]  byte_off,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_word,
  output logic [3:0]  lane_mask,
  output logic [31:0] wdata_lanes,
  output logic [31:0] rdata_aligned
);

  logic [31:0] rd_shifted;
  logic [31:0] size_mask;

  // NOTE: every output of a combinational block is assigned on every path,
  // so no latch can be inferred.
  always_comb begin
    lane_mask     = byte_sel << byte_off;
    wdata_lanes   = wdata << {byte_off, 3'b000};
    rd_shifted    = mem_word >> {byte_off, 3'b000};
    size_mask     = {{8{byte_sel[3]}}, {8{byte_sel[2]}}, {8{byte_sel[1]}}, {8{byte_sel[0]}}};
    rdata_aligned = rd_shifted & size_mask;
  end

endmodule

// File: rtl/riscv_dmem_resp.sv
// Single-outstanding data-memory responder with a programmable number of wait
// states, byte/half/word access and error reporting for illegal requests.
module riscv_dmem_resp
  import riscv_configs::*;
#(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_dmem_req_valid,
  output logic        o_dmem_req_ready,
  input  logic        i_dmem_wr_en,
  input  logic [3:0]  i_dmem_byte_sel,
  input  logic [31:0] i_dmem_addr,
  input  logic [31:0] i_dmem_wdata,
  output logic        o_dmem_rsp_valid,
  input  logic        i_dmem_rsp_ready,
  output logic [31:0] o_dmem_rdata,
  output logic        o_dmem_err
);

  localparam int         DEPTH     = 1 << DEPTH_LOG2;
  localparam bit         NO_WAIT   = (WAIT_CYCLES == 0);
  localparam logic [3:0] WAIT_LOAD = 4'(NO_WAIT ? 0 : WAIT_CYCLES - 1);

  dmem_state_e state;
  logic [3:0]  wait_cnt;

  logic        req_wr;
  logic [3:0]  req_sel;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic [31:0] mem [DEPTH];

  logic                  accept;
  logic                  enter_resp;
  logic                  cur_wr;
  logic                  cur_err;
  logic [3:0]            cur_sel;
  logic [31:0]           cur_addr;
  logic [31:0]           cur_wdata;
  logic [DEPTH_LOG2-1:0] word_idx;
  logic [3:0]            lane_mask;
  logic [31:0]           wdata_lanes;
  logic [31:0]           rdata_aligned;

  assign o_dmem_req_ready = (state == ST_IDLE);
  assign accept           = i_dmem_req_valid & o_dmem_req_ready;
  assign enter_resp       = (state == ST_WAIT && wait_cnt == 4'd0) || (accept && NO_WAIT);

  // In IDLE the live request is used, so a zero-wait access commits on its
  // own accept edge; otherwise the captured request drives the datapath.
  always_comb begin
    if (state == ST_IDLE) begin
      cur_wr    = i_dmem_wr_en;
      cur_sel   = i_dmem_byte_sel;
      cur_addr  = i_dmem_addr;
      cur_wdata = i_dmem_wdata;
    end else begin
      cur_wr    = req_wr;
      cur_sel   = req_sel;
      cur_addr  = req_addr;
      cur_wdata = req_wdata;
    end
    cur_err  = size_misaligned(cur_sel, cur_addr[1:0]) ||
               ((cur_addr >> (DEPTH_LOG2 + 2)) != 32'd0);
    word_idx = cur_addr[DEPTH_LOG2+1:2];
  end

  riscv_dmem_lane_align u_lane_align (
    .byte_sel      (cur_sel),
    .byte_off      (cur_addr[1:0]),
    .wdata         (cur_wdata),
    .mem_word      (mem[word_idx]),
    .lane_mask     (lane_mask),
    .wdata_lanes   (wdata_lanes),
    .rdata_aligned (rdata_aligned)
  );

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state            <= ST_IDLE;
      wait_cnt         <= 4'd0;
      o_dmem_rsp_valid <= 1'b0;
      o_dmem_rdata     <= 32'd0;
      o_dmem_err       <= 1'b0;
      req_wr           <= 1'b0;
      req_sel          <= 4'd0;
      req_addr         <= 32'd0;
      req_wdata        <= 32'd0;
    end else begin
      if (enter_resp) begin
        o_dmem_rsp_valid <= 1'b1;
        o_dmem_err       <= cur_err;
        o_dmem_rdata     <= (cur_err || cur_wr) ? 32'd0 : rdata_aligned;
      end
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            req_wr    <= i_dmem_wr_en;
            req_sel   <= i_dmem_byte_sel;
            req_addr  <= i_dmem_addr;
            req_wdata <= i_dmem_wdata;
            if (NO_WAIT) begin
              state <= ST_RESP;
            end else begin
              state    <= ST_WAIT;
              wait_cnt <= WAIT_LOAD;
            end
          end
        end
        ST_WAIT: begin
          if (wait_cnt == 4'd0) state <= ST_RESP;
          else                  wait_cnt <= wait_cnt - 4'd1;
        end
        ST_RESP: begin
          if (i_dmem_rsp_ready) begin
            state            <= ST_IDLE;
            o_dmem_rsp_valid <= 1'b0;
            o_dmem_rdata     <= 32'd0;
            o_dmem_err       <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: the array deliberately has no reset; only its write enable is
  // qualified by reset, so contents survive a reset pulse.
  always_ff @(posedge i_clk) begin
    if (enter_resp && cur_wr && !cur_err && i_rstn) begin
      for (int b = 0; b < 4; b++) begin
        if (lane_mask[b]) mem[word_idx][8*b +: 8] <= wdata_lanes[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_riscv_dmem_resp.sv
// Self-checking bench: directed corner cases plus random traffic against a
// byte-array reference model of the low 64 bytes of memory.
module tb_riscv_dmem_resp;

  localparam int DL = 10;
  localparam int WC = 1;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        wr_en = 1'b0;
  logic [3:0]  byte_sel = 4'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rdata;
  logic        err;

  int total = 0;
  int bad = 0;

  bit [7:0] mb [64];

  riscv_dmem_resp #(.DEPTH_LOG2(DL), .WAIT_CYCLES(WC)) dut (
    .i_clk            (clk),
    .i_rstn           (rstn),
    .i_dmem_req_valid (req_valid),
    .o_dmem_req_ready (req_ready),
    .i_dmem_wr_en     (wr_en),
    .i_dmem_byte_sel  (byte_sel),
    .i_dmem_addr      (addr),
    .i_dmem_wdata     (wdata),
    .o_dmem_rsp_valid (rsp_valid),
    .i_dmem_rsp_ready (rsp_ready),
    .o_dmem_rdata     (rdata),
    .o_dmem_err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit legal(input logic [3:0] s, input logic [31:0] a);
    if (a >= 32'(4 * (1 << DL))) return 1'b0;
    if (s == 4'b0001) return 1'b1;
    if (s == 4'b0011) return (a % 2) == 0;
    if (s == 4'b1111) return (a % 4) == 0;
    return 1'b0;
  endfunction

  task automatic do_op(input logic w, input logic [3:0] s, input logic [31:0] a,
                       input logic [31:0] d, input int hold, input string tag,
                       output logic [31:0] got);
    logic [31:0] exp_rd;
    logic        exp_err;
    int          lat;
    exp_err = !legal(s, a);
    exp_rd  = 32'd0;
    if (!exp_err) begin
      for (int i = 0; i < 4; i++) begin
        if (s[i]) begin
          if (w) mb[int'(a) + i] = d[8*i +: 8];
          else   exp_rd[8*i +: 8] = mb[int'(a) + i];
        end
      end
    end
    req_valid = 1'b1; wr_en = w; byte_sel = s; addr = a; wdata = d;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(WC + 1));
    check({tag, " rdata"}, rdata, exp_rd);
    check({tag, " err"}, 32'(err), 32'(exp_err));
    got = rdata;
    for (int c = 0; c < hold; c++) begin
      req_valid = 1'b1; wr_en = 1'b1; byte_sel = 4'hF; addr = 32'h0; wdata = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      check({tag, " hold valid"}, 32'(rsp_valid), 32'd1);
      check({tag, " hold rdata"}, rdata, exp_rd);
      check({tag, " hold err"}, 32'(err), 32'(exp_err));
      check({tag, " hold req_ready"}, 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check({tag, " exit rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, " exit req_ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] got;
    logic [31:0] ra;
    logic [3:0]  rs;
    logic        rw;

    #1;
    check("reset req_ready", 32'(req_ready), 32'd1);
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset rdata", rdata, 32'd0);
    check("reset err", 32'(err), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) do_op(1'b1, 4'hF, 32'(4 * i), $urandom(), 0, "init", got);

    do_op(1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF, 0, "st_word", got);
    do_op(1'b0, 4'hF, 32'h10, 32'h0, 0, "ld_word", got);
    check("ld_word value", got, 32'hDEAD_BEEF);

    do_op(1'b1, 4'hF, 32'h10, 32'h0, 0, "clr_word", got);
    do_op(1'b1, 4'h1, 32'h13, 32'h0000_00AB, 0, "st_byte", got);
    do_op(1'b0, 4'hF, 32'h10, 32'h0, 0, "ld_merged", got);
    check("ld_merged value", got, 32'hAB00_0000);
    do_op(1'b0, 4'h1, 32'h13, 32'h0, 0, "ld_byte", got);
    check("ld_byte value", got, 32'h0000_00AB);

    do_op(1'b0, 4'h3, 32'h11, 32'h0, 0, "ld_half_mis", got);
    do_op(1'b1, 4'hF, 32'h20, 32'h1111_2222, 0, "st_w20", got);
    do_op(1'b1, 4'hF, 32'h22, 32'h5555_6666, 0, "st_word_mis", got);
    do_op(1'b0, 4'hF, 32'h20, 32'h0, 0, "ld_w20", got);
    check("ld_w20 value", got, 32'h1111_2222);

    do_op(1'b0, 4'hF, 32'h0000_1000, 32'h0, 0, "ld_range", got);
    do_op(1'b0, 4'h7, 32'h0, 32'h0, 0, "ld_sel0111", got);

    do_op(1'b0, 4'hF, 32'h14, 32'h0, 5, "ld_hold", got);
    do_op(1'b0, 4'hF, 32'h0, 32'h0, 0, "ld_after_hold", got);

    req_valid = 1'b1; wr_en = 1'b1; byte_sel = 4'hF; addr = 32'h30; wdata = 32'h1234_5678;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rst_wait rsp_valid", 32'(rsp_valid), 32'd0);
    rstn = 1'b0;
    #1;
    check("rst_wait req_ready", 32'(req_ready), 32'd1);
    check("rst_wait rsp_valid low", 32'(rsp_valid), 32'd0);
    check("rst_wait rdata", rdata, 32'd0);
    check("rst_wait err", 32'(err), 32'd0);
    @(posedge clk);
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;
    do_op(1'b0, 4'hF, 32'h30, 32'h0, 0, "ld_after_rst", got);

    for (int n = 0; n < 60; n++) begin
      rw = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0:       rs = 4'b0001;
        1:       rs = 4'b0011;
        2, 3:    rs = 4'b1111;
        default: rs = 4'($urandom_range(0, 15));
      endcase
      ra = 32'($urandom_range(0, 63));
      if (rs == 4'b1111 && $urandom_range(0, 3) != 0) ra = ra & ~32'h3;
      if (rs == 4'b0011 && $urandom_range(0, 3) != 0) ra = ra & ~32'h1;
      if ($urandom_range(0, 9) == 0) ra = 32'h0000_1000 + 32'($urandom_range(0, 4095)) * 4;
      do_op(rw, rs, ra, $urandom(), 0, "rand", got);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/riscv_dmem_resp.md
RISCV_DMEM_RESP -- requirements
Module: riscv_dmem_resp

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 10, meaning log2 of memory depth in 32-bit words.
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, range 0..15, meaning wait states between request accept and response.
REQ-003 SHALL have one clock; reset is asynchronous and active-low: i_clk  input  1  rising-edge clock.
REQ-004 SHALL have port i_rstn  input  1  asynchronous active-low reset.
REQ-005 SHALL have port i_dmem_req_valid  input  1  request present.
REQ-006 SHALL have port o_dmem_req_ready  output  1  responder can accept a request.
REQ-007 SHALL have port i_dmem_wr_en  input  1  1 = store, 0 = load.
REQ-008 SHALL have port i_dmem_byte_sel  input  4  size mask, relative to the address: 0001 byte, 0011 half, 1111 word.
REQ-009 SHALL have port i_dmem_addr  input  32  byte address.
REQ-010 SHALL have port i_dmem_wdata  input  32  store data, right-aligned.
REQ-011 SHALL have port o_dmem_rsp_valid  output  1  response present.
REQ-012 SHALL have port i_dmem_rsp_ready  input  1  requester accepts the response.
REQ-013 SHALL have port o_dmem_rdata  output  32  load data, right-aligned and zero-filled above the size (0 for stores and errors).
REQ-014 SHALL have port o_dmem_err  output  1  misaligned, out-of-range or illegal-size request.

Function
REQ-015 SHALL implement an FSM with states IDLE, WAIT and RESP; o_dmem_req_ready = 1 only in IDLE.
REQ-016 SHALL accept a request on a rising edge with valid & ready, registering wr_en, byte_sel, addr and wdata.
REQ-017 SHALL go from IDLE to WAIT on accept when WAIT_CYCLES > 0 (counter loaded with WAIT_CYCLES-1), or directly to RESP when WAIT_CYCLES = 0.
REQ-018 SHALL decrement the counter in WAIT and enter RESP on the edge where it reads 0.
REQ-019 SHALL make the accept-to-rsp_valid latency exactly WAIT_CYCLES+1 cycles.
REQ-020 SHALL commit a store, and sample load data, on the edge that enters RESP; a load issued after a store to the same word returns the new data.
REQ-021 SHALL compute the lane mask as byte_sel << addr[1:0] and shift wdata left by 8*addr[1:0]; only masked bytes are written.
REQ-022 SHALL shift load data right by 8*addr[1:0] and zero the bytes outside byte_sel.
REQ-023 SHALL flag an error, with no memory write and rdata = 0, for any of: half with addr[0] = 1; word with addr[1:0] != 0; byte_sel not in {0001, 0011, 1111}; addr[31:DEPTH_LOG2+2] != 0.
REQ-024 SHALL hold rsp_valid, rdata and err stable in RESP until i_dmem_rsp_ready = 1, then return to IDLE on that edge.
REQ-025 SHALL leave req_ready low during the RESP-exit cycle, so there is no same-cycle back-to-back acceptance; the next accept is possible one cycle after returning to IDLE.
REQ-026 SHALL ignore i_dmem_req_valid outside IDLE.
REQ-027 SHALL hold o_dmem_rsp_valid at 0 outside RESP.

Reset
REQ-028 SHALL, while i_rstn = 0, force state IDLE, counter 0, o_dmem_rsp_valid 0, o_dmem_rdata 0 and o_dmem_err 0; o_dmem_req_ready therefore reads 1.
REQ-029 SHALL, on reset in WAIT, drop the pending store uncommitted; on reset in RESP, drop the response.
REQ-030 SHALL NOT reset the memory array contents.

Structure
REQ-031 SHALL place the FSM state encodings (IDLE, WAIT, RESP) and the size constants (BYTE 0001, HALF 0011, WORD 1111) in the shared riscv_configs package.
REQ-032 SHALL factor lane masking, write shift, read shift and zero-fill into one combinational sub-module, riscv_dmem_lane_align.

Verification
REQ-033 SHALL cover: WAIT_CYCLES=1; store word 0xDEADBEEF @0x10, then load word @0x10 -> rsp_valid 2 cycles after each accept, rdata 0xDEADBEEF, err 0.
REQ-034 SHALL cover: store byte 0xAB @0x13 over 0x00000000 @0x10, then load word @0x10 -> 0xAB000000; load byte @0x13 -> 0x000000AB.
REQ-035 SHALL cover: load half @0x11 -> err 1, rdata 0; store word @0x22 -> err 1 and word @0x20 unchanged.
REQ-036 SHALL cover: load @0x00001000 with DEPTH_LOG2=10 -> err 1; byte_sel 0111 -> err 1.
REQ-037 SHALL cover: rsp_ready held low 5 cycles in RESP -> rsp_valid, rdata and err stable, req_ready 0; new req_valid ignored.
REQ-038 SHALL cover: i_rstn pulsed low in WAIT of a store 0x12345678 @0x30 -> outputs at reset values, word @0x30 keeps its old value, next request served normally.
